// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the L1 I-cache (client 0) and D-cache (client 1).
// Registered downstream request stage, id-tagged combinational response routing, per-client credit counters.
module l1_mem_arbiter #(
    parameter int unsigned ADDR_BITS = 28,
    parameter int unsigned LINE_BITS = 128,
    parameter int unsigned ID_BITS   = 2,
    parameter int unsigned MAX_OUT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_req_valid,
    output logic                 i_req_ready,
    input  logic [ADDR_BITS-1:0] i_req_addr,
    input  logic [ID_BITS-1:0]   i_req_id,
    output logic                 i_resp_valid,
    input  logic                 i_resp_ready,
    output logic [LINE_BITS-1:0] i_resp_data,
    output logic [ID_BITS-1:0]   i_resp_id,

    input  logic                 d_req_valid,
    output logic                 d_req_ready,
    input  logic [ADDR_BITS-1:0] d_req_addr,
    input  logic                 d_req_we,
    input  logic [LINE_BITS-1:0] d_req_data,
    input  logic [ID_BITS-1:0]   d_req_id,
    output logic                 d_resp_valid,
    input  logic                 d_resp_ready,
    output logic [LINE_BITS-1:0] d_resp_data,
    output logic [ID_BITS-1:0]   d_resp_id,

    output logic                 m_req_valid,
    input  logic                 m_req_ready,
    output logic [ADDR_BITS-1:0] m_req_addr,
    output logic                 m_req_we,
    output logic [LINE_BITS-1:0] m_req_data,
    output logic [ID_BITS:0]     m_req_id,
    input  logic                 m_resp_valid,
    output logic                 m_resp_ready,
    input  logic [LINE_BITS-1:0] m_resp_data,
    input  logic [ID_BITS:0]     m_resp_id,

    output logic                 err
);

    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] cnt_i;
    logic [CNT_W-1:0] cnt_d;
    logic             last_grant;

    logic stage_free;
    logic i_elig;
    logic d_elig;
    logic grant_i;
    logic grant_d;
    logic resp_c;
    logic resp_fire;
    logic dec_i;
    logic dec_d;
    logic spurious;

    // Arbitration: a client at its credit limit is skipped so it never blocks the other.
    always_comb begin
        stage_free = !m_req_valid || m_req_ready;
        i_elig     = i_req_valid && (cnt_i < CNT_W'(MAX_OUT));
        d_elig     = d_req_valid && (cnt_d < CNT_W'(MAX_OUT));
        grant_i    = rst && stage_free && i_elig && (!d_elig || last_grant);
        grant_d    = rst && stage_free && d_elig && !grant_i;
        i_req_ready = grant_i;
        d_req_ready = grant_d;
    end

    // Response routing by client tag in the id MSB.
    always_comb begin
        resp_c       = m_resp_id[ID_BITS];
        i_resp_valid = m_resp_valid && !resp_c;
        d_resp_valid = m_resp_valid && resp_c;
        i_resp_data  = m_resp_data;
        d_resp_data  = m_resp_data;
        i_resp_id    = m_resp_id[ID_BITS-1:0];
        d_resp_id    = m_resp_id[ID_BITS-1:0];
        m_resp_ready = resp_c ? d_resp_ready : i_resp_ready;
        resp_fire    = m_resp_valid && m_resp_ready;
        dec_i        = resp_fire && !resp_c && (cnt_i != '0);
        dec_d        = resp_fire && resp_c && (cnt_d != '0);
        spurious     = m_resp_valid && (resp_c ? (cnt_d == '0) : (cnt_i == '0));
    end

    // Downstream request stage; payload holds while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_req_valid <= 1'b0;
            m_req_addr  <= '0;
            m_req_we    <= 1'b0;
            m_req_data  <= '0;
            m_req_id    <= '0;
            last_grant  <= 1'b1;
        end else if (stage_free) begin
            m_req_valid <= grant_i || grant_d;
            if (grant_i) begin
                m_req_addr <= i_req_addr;
                m_req_we   <= 1'b0;
                m_req_data <= '0;
                m_req_id   <= {1'b0, i_req_id};
                last_grant <= 1'b0;
            end else if (grant_d) begin
                m_req_addr <= d_req_addr;
                m_req_we   <= d_req_we;
                m_req_data <= d_req_data;
                m_req_id   <= {1'b1, d_req_id};
                last_grant <= 1'b1;
            end
        end
    end

    // Outstanding counters: simultaneous grant and response cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_i <= '0;
            cnt_d <= '0;
        end else begin
            case ({grant_i, dec_i})
                2'b10:   cnt_i <= cnt_i + CNT_W'(1);
                2'b01:   cnt_i <= cnt_i - CNT_W'(1);
                default: cnt_i <= cnt_i;
            endcase
            case ({grant_d, dec_d})
                2'b10:   cnt_d <= cnt_d + CNT_W'(1);
                2'b01:   cnt_d <= cnt_d - CNT_W'(1);
                default: cnt_d <= cnt_d;
            endcase
        end
    end

    // Sticky error on a response for a client with nothing outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (spurious) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: response-routing vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_l1_mem_arbiter;

    localparam int unsigned AB = 28;
    localparam int unsigned LB = 128;
    localparam int unsigned IB = 2;
    localparam int unsigned MO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req_valid, i_req_ready, i_resp_valid, i_resp_ready;
    logic [AB-1:0] i_req_addr;
    logic [IB-1:0] i_req_id, i_resp_id;
    logic [LB-1:0] i_resp_data;
    logic          d_req_valid, d_req_ready, d_req_we, d_resp_valid, d_resp_ready;
    logic [AB-1:0] d_req_addr;
    logic [LB-1:0] d_req_data, d_resp_data;
    logic [IB-1:0] d_req_id, d_resp_id;
    logic          m_req_valid, m_req_ready, m_req_we, m_resp_valid, m_resp_ready;
    logic [AB-1:0] m_req_addr;
    logic [LB-1:0] m_req_data, m_resp_data;
    logic [IB:0]   m_req_id, m_resp_id;
    logic          err;

    int checks = 0;
    int errors = 0;

    l1_mem_arbiter #(.ADDR_BITS(AB), .LINE_BITS(LB), .ID_BITS(IB), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr), .i_req_id(i_req_id),
        .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready), .i_resp_data(i_resp_data), .i_resp_id(i_resp_id),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
        .d_req_data(d_req_data), .d_req_id(d_req_id),
        .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_data(d_resp_data), .d_resp_id(d_resp_id),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr), .m_req_we(m_req_we),
        .m_req_data(m_req_data), .m_req_id(m_req_id),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_data(m_resp_data), .m_resp_id(m_resp_id),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        i_req_valid = 0; i_req_addr = '0; i_req_id = '0; i_resp_ready = 0;
        d_req_valid = 0; d_req_addr = '0; d_req_we = 0; d_req_data = '0; d_req_id = '0; d_resp_ready = 0;
        m_req_ready = 0; m_resp_valid = 0; m_resp_data = '0; m_resp_id = '0;
    endtask

    // Leaves the bench just after a negedge with reset released.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    typedef struct {
        logic        rv;
        logic [2:0]  rid;
        logic        irr;
        logic        drr;
        logic        exp_iv;
        logic        exp_dv;
        logic        exp_mr;
        logic [1:0]  exp_id;
    } resp_vec_t;

    resp_vec_t vec[8];

    // Reference model state (transaction level).
    typedef struct {
        logic          v;
        logic [AB-1:0] addr;
        logic          we;
        logic [LB-1:0] data;
        logic [IB:0]   id;
    } pend_t;

    pend_t       pend;
    int          cnt[2];
    int          last_c;
    logic [IB:0] mem_q[$];

    initial begin
        clear_inputs();
        rst = 0;
        #1;
        chk("reset_m_req_valid", LB'(m_req_valid), LB'(0));
        chk("reset_err", LB'(err), LB'(0));
        chk("reset_payload", m_req_data, LB'(0));
        chk("reset_i_ready", LB'(i_req_ready), LB'(0));

        // Response routing table (combinational path).
        vec[0] = '{1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1};
        vec[1] = '{1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2};
        vec[2] = '{1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3};
        vec[3] = '{1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vec[4] = '{1'b0, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        vec[5] = '{1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
        vec[6] = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        vec[7] = '{1'b1, 3'b110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            logic [LB-1:0] dat;
            dat = {$urandom, $urandom, $urandom, $urandom};
            m_resp_valid = vec[k].rv; m_resp_id = vec[k].rid; m_resp_data = dat;
            i_resp_ready = vec[k].irr; d_resp_ready = vec[k].drr;
            #1;
            chk("tbl_i_resp_valid", LB'(i_resp_valid), LB'(vec[k].exp_iv));
            chk("tbl_d_resp_valid", LB'(d_resp_valid), LB'(vec[k].exp_dv));
            chk("tbl_m_resp_ready", LB'(m_resp_ready), LB'(vec[k].exp_mr));
            chk("tbl_i_resp_id", LB'(i_resp_id), LB'(vec[k].exp_id));
            chk("tbl_d_resp_id", LB'(d_resp_id), LB'(vec[k].exp_id));
            chk("tbl_resp_data", vec[k].rid[2] ? d_resp_data : i_resp_data, dat);
            @(negedge clk);
        end

        // Single I request and its response.
        do_reset();
        chk("post_reset_err", LB'(err), LB'(0));
        i_req_valid = 1; i_req_addr = 28'h0000123; i_req_id = 2'd1;
        #1;
        chk("single_i_ready", LB'(i_req_ready), LB'(1));
        chk("single_d_ready", LB'(d_req_ready), LB'(0));
        @(posedge clk); #1;
        i_req_valid = 0;
        chk("single_m_valid", LB'(m_req_valid), LB'(1));
        chk("single_m_id", LB'(m_req_id), LB'(3'b001));
        chk("single_m_we", LB'(m_req_we), LB'(0));
        chk("single_m_addr", LB'(m_req_addr), LB'(28'h0000123));
        @(negedge clk);
        m_req_ready = 1;
        @(negedge clk);
        m_req_ready = 0;
        chk("single_drained", LB'(m_req_valid), LB'(0));
        m_resp_valid = 1; m_resp_id = 3'b001; m_resp_data = 128'h1234; i_resp_ready = 1;
        #1;
        chk("single_i_resp_valid", LB'(i_resp_valid), LB'(1));
        chk("single_i_resp_id", LB'(i_resp_id), LB'(1));
        chk("single_d_resp_valid", LB'(d_resp_valid), LB'(0));
        @(negedge clk);
        m_resp_valid = 0;
        chk("single_no_err", LB'(err), LB'(0));

        // Alternation with both clients always requesting.
        do_reset();
        i_req_valid = 1; d_req_valid = 1; m_req_ready = 1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("alt_client", LB'(m_req_id[IB]), LB'(k % 2));
        end

        // D write stalled downstream.
        do_reset();
        d_req_valid = 1; d_req_we = 1; d_req_addr = 28'h00000AB; d_req_data = 128'hDEAD_BEEF; d_req_id = 2'd2;
        #1;
        chk("stall_first_ready", LB'(d_req_ready), LB'(1));
        @(negedge clk);
        d_req_addr = 28'h00000AC; d_req_data = 128'h5555; d_req_id = 2'd3;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_valid", LB'(m_req_valid), LB'(1));
            chk("stall_addr", LB'(m_req_addr), LB'(28'h00000AB));
            chk("stall_data", m_req_data, 128'hDEAD_BEEF);
            chk("stall_we", LB'(m_req_we), LB'(1));
            chk("stall_id", LB'(m_req_id), LB'(3'b110));
            chk("stall_d_ready", LB'(d_req_ready), LB'(0));
            @(negedge clk);
        end
        m_req_ready = 1;
        #1;
        chk("stall_release_ready", LB'(d_req_ready), LB'(1));
        @(posedge clk); #1;
        chk("stall_next_addr", LB'(m_req_addr), LB'(28'h00000AC));
        chk("stall_next_id", LB'(m_req_id), LB'(3'b111));

        // Credit limit on D does not block I.
        do_reset();
        m_req_ready = 1; d_req_valid = 1;
        for (int k = 0; k < MO; k++) begin
            #1;
            chk("limit_d_ready", LB'(d_req_ready), LB'(1));
            @(negedge clk);
        end
        i_req_valid = 1;
        #1;
        chk("limit_d_blocked", LB'(d_req_ready), LB'(0));
        chk("limit_i_granted", LB'(i_req_ready), LB'(1));
        @(negedge clk);
        i_req_valid = 0;
        m_resp_valid = 1; m_resp_id = 3'b100; d_resp_ready = 1;
        #1;
        chk("limit_d_still_blocked", LB'(d_req_ready), LB'(0));
        chk("limit_d_resp_valid", LB'(d_resp_valid), LB'(1));
        @(negedge clk);
        m_resp_valid = 0;
        #1;
        chk("limit_d_regranted", LB'(d_req_ready), LB'(1));
        @(posedge clk); #1;
        chk("limit_d_issued", LB'(m_req_id[IB]), LB'(1));
        chk("limit_no_err", LB'(err), LB'(0));

        // Spurious response sets sticky error.
        do_reset();
        m_resp_valid = 1; m_resp_id = 3'b100; d_resp_ready = 1;
        #1;
        chk("err_d_resp_valid", LB'(d_resp_valid), LB'(1));
        @(negedge clk);
        m_resp_valid = 0;
        for (int k = 0; k < 3; k++) begin
            chk("err_sticky", LB'(err), LB'(1));
            @(negedge clk);
        end
        rst = 0;
        #1;
        chk("err_cleared", LB'(err), LB'(0));

        // Reset in the middle of a burst.
        do_reset();
        i_req_valid = 1; d_req_valid = 1; m_req_ready = 1;
        repeat (3) @(negedge clk);
        #2;
        rst = 0;
        #1;
        chk("midrst_m_valid", LB'(m_req_valid), LB'(0));
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        chk("midrst_first_i", LB'(m_req_id), LB'(3'b000));

        // Randomized traffic against reference model.
        do_reset();
        pend = '{1'b0, '0, 1'b0, '0, '0};
        cnt[0] = 0; cnt[1] = 0; last_c = 1;
        mem_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int          g;
            int          pick;
            bit          sf;
            bit          e0;
            bit          e1;
            bit          c;
            bit          fire;
            i_req_valid  = ($urandom % 3) != 0;
            i_req_addr   = AB'($urandom);
            i_req_id     = IB'($urandom);
            d_req_valid  = ($urandom % 3) != 0;
            d_req_addr   = AB'($urandom);
            d_req_we     = 1'($urandom);
            d_req_data   = {$urandom, $urandom, $urandom, $urandom};
            d_req_id     = IB'($urandom);
            m_req_ready  = ($urandom % 4) != 0;
            i_resp_ready = ($urandom % 4) != 0;
            d_resp_ready = ($urandom % 4) != 0;
            m_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            pick = -1;
            m_resp_valid = 0;
            m_resp_id    = '0;
            if (mem_q.size() > 0 && ($urandom % 3) != 0) begin
                pick = int'($urandom_range(0, mem_q.size() - 1));
                m_resp_valid = 1;
                m_resp_id = mem_q[pick];
            end
            #1;
            sf = !pend.v || m_req_ready;
            e0 = i_req_valid && cnt[0] < MO;
            e1 = d_req_valid && cnt[1] < MO;
            g = -1;
            if (sf) begin
                if (e0 && e1) g = (last_c == 0) ? 1 : 0;
                else if (e0)  g = 0;
                else if (e1)  g = 1;
            end
            c = m_resp_id[IB];
            fire = m_resp_valid && (c ? d_resp_ready : i_resp_ready);
            chk("rnd_i_ready", LB'(i_req_ready), LB'(g == 0));
            chk("rnd_d_ready", LB'(d_req_ready), LB'(g == 1));
            chk("rnd_m_valid", LB'(m_req_valid), LB'(pend.v));
            if (pend.v) begin
                chk("rnd_m_addr", LB'(m_req_addr), LB'(pend.addr));
                chk("rnd_m_we", LB'(m_req_we), LB'(pend.we));
                chk("rnd_m_data", m_req_data, pend.data);
                chk("rnd_m_id", LB'(m_req_id), LB'(pend.id));
            end
            chk("rnd_i_resp_valid", LB'(i_resp_valid), LB'(m_resp_valid && !c));
            chk("rnd_d_resp_valid", LB'(d_resp_valid), LB'(m_resp_valid && c));
            chk("rnd_m_resp_ready", LB'(m_resp_ready), LB'(c ? d_resp_ready : i_resp_ready));
            chk("rnd_err", LB'(err), LB'(0));
            // Model update for the coming edge.
            if (pend.v && m_req_ready) mem_q.push_back(pend.id);
            if (fire) begin
                mem_q.delete(pick);
                cnt[c]--;
            end
            if (g == 0) begin
                pend = '{1'b1, i_req_addr, 1'b0, '0, {1'b0, i_req_id}};
                cnt[0]++; last_c = 0;
            end else if (g == 1) begin
                pend = '{1'b1, d_req_addr, d_req_we, d_req_data, {1'b1, d_req_id}};
                cnt[1]++; last_c = 1;
            end else if (sf) begin
                pend.v = 1'b0;
            end
            @(negedge clk);
        end
        clear_inputs();
        @(negedge clk);
        chk("rnd_final_err", LB'(err), LB'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
